system_led_pio_out: RTL
=======================

SYSTEM_LED_PIO_OUT -- requirements
Module: system_led_pio_out

Interface
REQ-001 Parameter WIDTH, default 18: number of output port bits (1..32).
REQ-002 Parameter CNT_W, default 26: blink counter and period register width (1..32).
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data; bits above WIDTH (or CNT_W for PERIOD) SHALL be ignored.
REQ-009 readdata  output  32  registered read data, zero-extended.
REQ-010 out_port  output  WIDTH  registered LED drive.

Function
REQ-011 A write SHALL be accepted on any rising edge where chipselect=1 and write_n=0; there are no wait states.
REQ-012 Register map: 0 DATA (RW), 1 BLINK_MASK (RW), 2 BLINK_PERIOD (RW), 3 STATUS (RO, bit0 = blink phase), 4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 unmapped.
REQ-013 A DATA write SHALL replace data_reg; an OUTSET write SHALL set data_reg |= writedata; an OUTCLEAR write SHALL set data_reg &= ~writedata.
REQ-014 Reads of OUTSET, OUTCLEAR, 6 and 7 SHALL return 0; writes to STATUS, 6 and 7 SHALL be ignored.
REQ-015 readdata SHALL be loaded every edge with the selected register when chipselect=1, else 0; the read latency SHALL be exactly 1 cycle.
REQ-016 A read in the same cycle as a write to the same register SHALL return the pre-write value.
REQ-017 Blink counter: when BLINK_PERIOD=P>0, the counter SHALL count 0..P and then wrap to 0, and phase SHALL toggle on each wrap, so each half-period lasts P+1 cycles.
REQ-018 When BLINK_PERIOD=0, the counter SHALL hold 0 and phase SHALL be forced to 1.
REQ-019 A BLINK_PERIOD write SHALL clear the counter and set phase=1 on the same edge; this SHALL take priority over a simultaneous wrap.
REQ-020 out_port SHALL be registered as data_next & ~(mask_next & {WIDTH{~phase_next}}), so an accepted write is visible on out_port after the edge that accepts it.
REQ-021 The counter SHALL saturate-compare as unsigned CNT_W bits; P = 2^CNT_W-1 SHALL wrap without overflow.

Reset
REQ-022 Assertion of reset_n=0 SHALL asynchronously clear data_reg, mask, period, counter, readdata and out_port to 0, and set phase to 1.
REQ-023 Reset asserted mid-blink or mid-read SHALL abort the operation with no residual state; the first write after deassertion SHALL behave as in REQ-011.

Configuration
REQ-024 Macro LED_PIO_BLINK_EN: when defined, the blink logic (REQ-017..019, mask and period registers) SHALL be compiled in.
REQ-025 When LED_PIO_BLINK_EN is undefined, addresses 1 and 2 SHALL read 0 with writes ignored, STATUS bit0 SHALL read 1, no counter SHALL be instantiated, and out_port SHALL equal data_reg.

Verification
REQ-026 Reset, then write DATA=0x2AAAA -> out_port=0x2AAAA the cycle after the write; read addr 0 returns 0x0002AAAA with 1-cycle latency.
REQ-027 DATA=0x00F0, OUTSET 0x000F, then OUTCLEAR 0x0030 -> out_port sequence 0x00F0, 0x00FF, 0x00CF; reads of addr 4/5 return 0.
REQ-028 DATA=0x3FFFF, MASK=0x00003, PERIOD=3 -> bits[1:0] alternate on/off every 4 cycles; STATUS bit0 tracks the phase; bits[17:2] stay 1.
REQ-029 Rewriting PERIOD=3 on the cycle the counter would wrap -> phase=1, counter=0, with no toggle that cycle.
REQ-030 reset_n pulsed low mid-blink with out_port nonzero -> out_port=0 and readdata=0 immediately; STATUS reads 1 after release.
REQ-031 Build without LED_PIO_BLINK_EN, write MASK=0x3, PERIOD=1 -> addresses 1/2 read 0, and out_port equals DATA with no toggling.

Source files
------------

// File: rtl/system_led_pio_out.sv
// system_led_pio_out: Avalon-MM memory-mapped LED output port. It has set and
// clear registers and optional hardware blinking.
//
// Build option: define LED_PIO_BLINK_EN to compile in the blink mask, the blink
// period register and the blink counter. When the macro is undefined,
// addresses 1 and 2 read 0, STATUS bit0 reads 1, and out_port follows DATA.
//
// Register map (word addresses):
//   0 DATA (RW)   1 BLINK_MASK (RW)   2 BLINK_PERIOD (RW)   3 STATUS (RO, bit0 = phase)
//   4 OUTSET (WO) 5 OUTCLEAR (WO)     6-7 unmapped (read 0, writes ignored)
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   address[2:0]            word address
//   chipselect, write_n     slave select, active-low write strobe
//   writedata[31:0]         write data (bits above the register width are ignored)
//   readdata[31:0]          registered read data, 1-cycle latency, zero-extended
//   out_port[WIDTH-1:0]     registered LED drive
module system_led_pio_out #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic             write_en;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] mask_next;
  logic             phase_cur;
  logic             phase_next;
  logic [DW-1:0]    rd_next;
  logic [WIDTH-1:0] out_next;

  // Upper writedata bits are deliberately dropped.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign write_en = chipselect & ~write_n;
  assign wdata_w  = writedata[WIDTH-1:0];

  // DATA register update, including the set and clear aliases.
  always_comb begin
    data_next = data_reg;
    if (write_en) begin
      case (address)
        ADDR_DATA:   data_next = wdata_w;
        ADDR_OUTSET: data_next = data_reg | wdata_w;
        ADDR_OUTCLR: data_next = data_reg & ~wdata_w;
        default:     data_next = data_reg;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0] mask_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             phase_reg;

  // Mask and period register updates.
  always_comb begin
    mask_next   = mask_reg;
    period_next = period_reg;
    if (write_en && (address == ADDR_MASK))   mask_next   = wdata_w;
    if (write_en && (address == ADDR_PERIOD)) period_next = writedata[CNT_W-1:0];
  end

  // Blink counter. A period write restarts the counter and wins over a wrap.
  // Wrap is detected by equality, so the largest period never overflows.
  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (write_en && (address == ADDR_PERIOD)) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (period_reg == '0) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt_reg == period_reg) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end else begin
      cnt_next   = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg   <= '0;
      period_reg <= '0;
      cnt_reg    <= '0;
      phase_reg  <= 1'b1;
    end else begin
      mask_reg   <= mask_next;
      period_reg <= period_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
    end
  end

  assign phase_cur = phase_reg;
`else
  // Without blinking the phase is permanently "on" and nothing is masked.
  assign mask_next  = '0;
  assign phase_next = 1'b1;
  assign phase_cur  = 1'b1;
`endif

  // Read mux. It samples the pre-write register values.
  always_comb begin
    rd_next = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:   rd_next = DW'(data_reg);
`ifdef LED_PIO_BLINK_EN
        ADDR_MASK:   rd_next = DW'(mask_reg);
        ADDR_PERIOD: rd_next = DW'(period_reg);
`endif
        ADDR_STATUS: rd_next = DW'(phase_cur);
        default:     rd_next = '0;
      endcase
    end
  end

  // Masked bits go dark during the off phase.
  assign out_next = data_next & ~(mask_next & {WIDTH{~phase_next}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
      readdata <= '0;
      out_port <= '0;
    end else begin
      data_reg <= data_next;
      readdata <= rd_next;
      out_port <= out_next;
    end
  end

endmodule
